// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings for the load/store unit
// funct3 codes, FSM states and byte-mask constants
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] MASK_NONE = 4'b0000;
  localparam logic [3:0] MASK_B    = 4'b0001;
  localparam logic [3:0] MASK_H    = 4'b0011;
  localparam logic [3:0] MASK_W    = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } lsu_state_e;

endpackage

// File: rtl/lsu_mem_master_align.sv
// lsu_mem_master_align: legality check, store lane
// replication/byte mask, load extraction/extension
module lsu_mem_master_align
  import lsu_pkg::*;
(
  input  logic        store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_data,
  output logic        ok,
  output logic [3:0]  st_mask,
  output logic [31:0] st_data,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;

  assign shifted = mem_data >> {off, 3'b000};

  // legality, alignment and store lane generation
  always_comb begin
    ok      = 1'b0;
    st_mask = MASK_NONE;
    st_data = wdata;
    case (funct3)
      F3_B: begin
        ok      = 1'b1;
        st_mask = MASK_B << off;
        st_data = {4{wdata[7:0]}};
      end
      F3_H: begin
        ok      = ~off[0];
        st_mask = MASK_H << off;
        st_data = {2{wdata[15:0]}};
      end
      F3_W: begin
        ok      = (off == 2'b00);
        st_mask = MASK_W;
      end
      F3_BU:   ok = ~store;
      F3_HU:   ok = ~store & ~off[0];
      default: ok = 1'b0;
    endcase
    if (!ok || !store) st_mask = MASK_NONE;
  end

  // load lane extraction with sign/zero extension
  always_comb begin
    ld_data = '0;
    case (funct3)
      F3_B:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:  ld_data = mem_data;
      F3_BU: ld_data = {24'h0, shifted[7:0]};
      F3_HU: ld_data = {16'h0, shifted[15:0]};
      default: ld_data = '0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: one-at-a-time load/store initiator
// for a registered synchronous RAM data port
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_data
);

  lsu_state_e  state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        store_q, store_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_wmask_q, mem_wmask_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic        idle;
  logic        a_store;
  logic [2:0]  a_f3;
  logic [1:0]  a_off;
  logic        a_ok;
  logic [3:0]  a_mask;
  logic [31:0] a_sdata;
  logic [31:0] a_ldata;

  assign idle    = (state_q == IDLE);
  assign a_store = idle ? req_store       : store_q;
  assign a_f3    = idle ? req_funct3      : f3_q;
  assign a_off   = idle ? req_addr[1:0]   : off_q;

  lsu_mem_master_align u_align (
    .store    (a_store),
    .funct3   (a_f3),
    .off      (a_off),
    .wdata    (req_wdata),
    .mem_data (mem_data),
    .ok       (a_ok),
    .st_mask  (a_mask),
    .st_data  (a_sdata),
    .ld_data  (a_ldata)
  );

  // next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    store_d     = store_q;
    f3_d        = f3_q;
    off_d       = off_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_addr_d  = mem_addr_q;
    mem_wmask_d = mem_wmask_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          store_d = req_store;
          f3_d    = req_funct3;
          off_d   = req_addr[1:0];
          if (a_ok) begin
            state_d    = ISSUE;
            mem_addr_d = {req_addr[31:2], 2'b00};
            if (req_store) begin
              mem_wmask_d = a_mask;
              mem_wdata_d = a_sdata;
            end
          end else begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end
        end
      end
      ISSUE: begin
        mem_wmask_d = MASK_NONE;
        if (store_q) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
        end else begin
          state_d = WAIT;
          cnt_d   = 2'(RD_LAT);
        end
      end
      WAIT: begin
        if (cnt_q == 2'd1) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = a_ldata;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state and output registers, async reset drops wmask at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      store_q     <= 1'b0;
      f3_q        <= '0;
      off_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wmask_q <= MASK_NONE;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      store_q     <= store_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mem_addr_q  <= mem_addr_d;
      mem_wmask_q <= mem_wmask_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign req_ready = idle;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wmask = mem_wmask_q;
  assign mem_wdata = mem_wdata_q;

endmodule
